// File: rtl/int_request_ctrl_pkg.sv
// Shared definitions for the interrupt request controller: MMIO word offsets,
// handshake FSM state encodings, enable/disable levels and the priority helper.
package int_request_ctrl_pkg;

   // MMIO word offsets inside the 4-word register window
   localparam logic [1:0] INTC_ADDR_PENDING = 2'd0;
   localparam logic [1:0] INTC_ADDR_MASK    = 2'd1;
   localparam logic [1:0] INTC_ADDR_ACTIVE  = 2'd2;

   // Generic enable/disable levels reused across the board I/O blocks
   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // Bit position of the "request outstanding" flag in the ACTIVE register
   localparam int ACTIVE_REQ_BIT = 8;

   // Handshake FSM state encodings
   typedef enum logic [1:0] {
      INTC_IDLE = 2'd0,
      INTC_REQ  = 2'd1,
      INTC_HOLD = 2'd2
   } intc_state_t;

   // Priority encoder: index of the lowest set bit (index 0 = highest priority).
   // Returns 0 for an all-zero vector; callers qualify with a separate any-bit test.
   function automatic logic [2:0] lowest_set(input logic [7:0] vec);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/int_src_sync.sv
// Per-source input conditioning: a SYNC_STAGES-deep synchroniser for a raw
// asynchronous interrupt line followed by a single history flop, producing a
// one-cycle rise strobe when the synchronised level goes from 0 to 1.
module int_src_sync
   import int_request_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic src,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   // Synchroniser shift chain plus previous-level flop for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r <= '0;
         prev_r <= DISABLE;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], src};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   // Rising edge of the synchronised level; feeds the pending latch directly
   always_comb begin
      rise = sync_r[SYNC_STAGES-1] & ~prev_r;
   end

endmodule

// File: rtl/int_request_ctrl.sv
// Requester side of the CPU interrupt handshake. Raw sources are synchronised
// and edge-detected, captured into PENDING, gated by MASK and prioritised
// (lowest index wins). A three-state FSM raises INT towards CP0, freezes the
// chosen int_id until the INT_ACK pulse retires it, and then holds INT low for
// HOLDOFF cycles so CP0 always sees a low level between two requests.
// A small MMIO window exposes PENDING (W1C), MASK (R/W) and ACTIVE (RO).
module int_request_ctrl
   import int_request_ctrl_pkg::*;
#(
   parameter int N_SRC       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   output logic             INT,
   input  logic             INT_ACK,
   output logic [2:0]       int_id,
   input  logic [1:0]       bus_addr,
   input  logic             bus_we,
   input  logic [31:0]      bus_wdata,
   output logic [31:0]      bus_rdata
);

   localparam int               CNT_W        = $clog2(HOLDOFF + 1);
   localparam logic [CNT_W-1:0] HOLDOFF_INIT = CNT_W'(HOLDOFF);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
   localparam logic [N_SRC-1:0] SRC_ONE      = N_SRC'(1'b1);

   // Edge strobes from the per-source conditioners
   logic [N_SRC-1:0] rise;

   // Register state
   logic [N_SRC-1:0] pending_r;
   logic [N_SRC-1:0] mask_r;
   intc_state_t      state_r;
   logic             int_r;
   logic [2:0]       id_r;
   logic [CNT_W-1:0] cnt_r;

   // Next-state values
   logic [N_SRC-1:0] pending_nxt;
   logic [N_SRC-1:0] mask_nxt;
   intc_state_t      state_nxt;
   logic             int_nxt;
   logic [2:0]       id_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   // Decoded control
   logic             w1c_sel;
   logic             mask_sel;
   logic             ack_take;
   logic [N_SRC-1:0] id_onehot;
   logic [N_SRC-1:0] pending_clr;
   logic [N_SRC-1:0] eligible;
   logic             any_eligible;
   logic [2:0]       winner;
   logic             still_valid;

   // Write-data bits above the source field have no storage behind them
   logic             unused_wdata;
   assign unused_wdata = ^bus_wdata;

   genvar g;
   generate
      for (g = 0; g < N_SRC; g++) begin : g_src
         int_src_sync #(
            .SYNC_STAGES(SYNC_STAGES)
         ) u_sync (
            .clk   (clk),
            .reset (reset),
            .src   (irq_src[g]),
            .rise  (rise[g])
         );
      end
   endgenerate

   // Bus decode, pending/mask next values and the prioritised winner
   always_comb begin
      w1c_sel      = bus_we & (bus_addr == INTC_ADDR_PENDING);
      mask_sel     = bus_we & (bus_addr == INTC_ADDR_MASK);
      // An ack only counts while a request is actually outstanding
      ack_take     = INT_ACK & (state_r == INTC_REQ);
      id_onehot    = SRC_ONE << id_r;
      pending_clr  = (ack_take ? id_onehot : '0) |
                     (w1c_sel ? bus_wdata[N_SRC-1:0] : '0);
      // A fresh edge beats any clear of the same bit in the same cycle
      pending_nxt  = (pending_r & ~pending_clr) | rise;
      mask_nxt     = mask_sel ? bus_wdata[N_SRC-1:0] : mask_r;
      eligible     = pending_r & mask_r;
      any_eligible = |eligible;
      winner       = lowest_set(8'(eligible));
      // The frozen request stays valid only while its source stays pending and enabled
      still_valid  = |(pending_nxt & mask_nxt & id_onehot);
   end

   // Pending and mask storage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_r <= '0;
         mask_r    <= '1;
      end else begin
         pending_r <= pending_nxt;
         mask_r    <= mask_nxt;
      end
   end

   // FSM state register together with the registered INT/int_id/holdoff outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= INTC_IDLE;
         int_r   <= DISABLE;
         id_r    <= 3'd0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt;
         int_r   <= int_nxt;
         id_r    <= id_nxt;
         cnt_r   <= cnt_nxt;
      end
   end

   // Next-state logic of the request handshake
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         INTC_IDLE: begin
            if (any_eligible) begin
               state_nxt = INTC_REQ;
            end else begin
               state_nxt = INTC_IDLE;
            end
         end
         INTC_REQ: begin
            if (ack_take) begin
               state_nxt = INTC_HOLD;
            end else if (!still_valid) begin
               state_nxt = INTC_IDLE;
            end else begin
               state_nxt = INTC_REQ;
            end
         end
         INTC_HOLD: begin
            if (cnt_r <= CNT_ONE) begin
               state_nxt = INTC_IDLE;
            end else begin
               state_nxt = INTC_HOLD;
            end
         end
         default: begin
            state_nxt = INTC_IDLE;
         end
      endcase
   end

   // Output logic: INT level, id latch on request entry, holdoff down-counter
   always_comb begin
      int_nxt = (state_nxt == INTC_REQ) ? ENABLE : DISABLE;
      id_nxt  = id_r;
      cnt_nxt = '0;
      case (state_r)
         INTC_IDLE: begin
            if (any_eligible) begin
               id_nxt = winner;
            end else begin
               id_nxt = id_r;
            end
         end
         INTC_REQ: begin
            if (ack_take) begin
               cnt_nxt = HOLDOFF_INIT;
            end else begin
               cnt_nxt = '0;
            end
         end
         INTC_HOLD: begin
            if (cnt_r > CNT_ONE) begin
               cnt_nxt = cnt_r - CNT_ONE;
            end else begin
               cnt_nxt = '0;
            end
         end
         default: begin
            id_nxt  = id_r;
            cnt_nxt = '0;
         end
      endcase
   end

   // MMIO read mux; unused and reserved bits read as zero
   always_comb begin
      bus_rdata = 32'd0;
      case (bus_addr)
         INTC_ADDR_PENDING: begin
            bus_rdata = 32'(pending_r);
         end
         INTC_ADDR_MASK: begin
            bus_rdata = 32'(mask_r);
         end
         INTC_ADDR_ACTIVE: begin
            bus_rdata[ACTIVE_REQ_BIT] = (state_r == INTC_REQ);
            bus_rdata[2:0]            = id_r;
         end
         default: begin
            bus_rdata = 32'd0;
         end
      endcase
   end

   assign INT    = int_r;
   assign int_id = id_r;

endmodule

// File: tb/tb_int_request_ctrl.sv
// Bench for int_request_ctrl: directed handshake sequences, a vector table for
// the masked-capture case, and randomized traffic checked every cycle against
// a behavioural model of the controller.
module tb_int_request_ctrl;

   localparam int N_SRC       = 4;
   localparam int SYNC_STAGES = 2;
   localparam int HOLDOFF     = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq_src;
   logic        INT;
   logic        INT_ACK;
   logic [2:0]  int_id;
   logic [1:0]  bus_addr;
   logic        bus_we;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   int_request_ctrl #(
      .N_SRC(N_SRC), .SYNC_STAGES(SYNC_STAGES), .HOLDOFF(HOLDOFF)
   ) dut (
      .clk(clk), .reset(reset), .irq_src(irq_src), .INT(INT), .INT_ACK(INT_ACK),
      .int_id(int_id), .bus_addr(bus_addr), .bus_we(bus_we),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
   );

   // ---------------- behavioural model ----------------
   logic [3:0] m_pend;
   logic [3:0] m_mask;
   logic       m_int;
   logic [2:0] m_id;
   int         m_earliest;   // first edge at which a new request may be raised
   int         cyc;          // edges since reset release
   logic [3:0] hist[$];      // hist[k-1] = irq_src sampled at edge k

   function automatic logic [3:0] sample_at(input int k);
      if (k < 1 || k > hist.size()) return 4'd0;
      return hist[k-1];
   endfunction

   function automatic logic [2:0] lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return 3'(i);
      return 3'd0;
   endfunction

   function automatic logic [31:0] model_rdata();
      case (bus_addr)
         2'd0:    return {28'd0, m_pend};
         2'd1:    return {28'd0, m_mask};
         2'd2:    return {23'd0, m_int, 5'd0, m_id};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_pend = 4'd0; m_mask = 4'hF; m_int = 1'b0; m_id = 3'd0;
      m_earliest = 0; cyc = 0; hist.delete();
   endtask

   task automatic model_edge();
      logic [3:0] rise, clr, pn, mn;
      cyc++;
      hist.push_back(irq_src);
      // a level change is seen SYNC_STAGES edges later and captured on that edge
      rise = sample_at(cyc - SYNC_STAGES) & ~sample_at(cyc - SYNC_STAGES - 1);
      clr = 4'd0;
      if (m_int && INT_ACK) clr[m_id[1:0]] = 1'b1;
      if (bus_we && bus_addr == 2'd0) clr = clr | bus_wdata[3:0];
      pn = (m_pend & ~clr) | rise;
      mn = (bus_we && bus_addr == 2'd1) ? bus_wdata[3:0] : m_mask;
      if (m_int) begin
         if (INT_ACK) begin
            m_int = 1'b0;
            m_earliest = cyc + HOLDOFF + 1;
         end else if (!pn[m_id[1:0]] || !mn[m_id[1:0]]) begin
            m_int = 1'b0;
            m_earliest = cyc + 1;
         end
      end else if (cyc >= m_earliest && (m_pend & m_mask) != 4'd0) begin
         m_int = 1'b1;
         m_id = lowest(m_pend & m_mask);
      end
      m_pend = pn;
      m_mask = mn;
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_edge();
      #1;
      check("model_int", 32'(INT), 32'(m_int));
      check("model_int_id", 32'(int_id), 32'(m_id));
      check("model_rdata", bus_rdata, model_rdata());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_src(input logic [3:0] v);
      irq_src = v;
      idle(3);
      irq_src = 4'd0;
   endtask

   task automatic ack_pulse();
      INT_ACK = 1'b1;
      step();
      INT_ACK = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus_addr = a; bus_we = 1'b1; bus_wdata = d;
      step();
      bus_we = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      bus_addr = a;
      #1;
      check(name, bus_rdata, exp);
   endtask

   task automatic wait_int(input int budget, output int n);
      n = 0;
      while (INT !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check("wait_int_timeout", 32'(INT), 32'd1);
   endtask

   typedef struct {
      logic [3:0]  src;
      logic        ack;
      logic [1:0]  addr;
      logic        we;
      logic [31:0] wdata;
      logic        exp_int;
      logic [2:0]  exp_id;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [0:8];

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int first;

      // masked-capture scenario: rows are inputs for one edge, then outputs after it
      tbl[0] = '{src:4'b0000, ack:1'b0, addr:2'd1, we:1'b1, wdata:32'hD, exp_int:1'b0, exp_id:3'd2, exp_rd:32'hD};
      tbl[1] = '{src:4'b0010, ack:1'b0, addr:2'd0, we:1'b0, wdata:32'h0, exp_int:1'b0, exp_id:3'd2, exp_rd:32'h0};
      tbl[2] = '{src:4'b0010, ack:1'b0, addr:2'd0, we:1'b0, wdata:32'h0, exp_int:1'b0, exp_id:3'd2, exp_rd:32'h0};
      tbl[3] = '{src:4'b0010, ack:1'b0, addr:2'd0, we:1'b0, wdata:32'h0, exp_int:1'b0, exp_id:3'd2, exp_rd:32'h2};
      tbl[4] = '{src:4'b0000, ack:1'b0, addr:2'd0, we:1'b0, wdata:32'h0, exp_int:1'b0, exp_id:3'd2, exp_rd:32'h2};
      tbl[5] = '{src:4'b0000, ack:1'b0, addr:2'd1, we:1'b1, wdata:32'hF, exp_int:1'b0, exp_id:3'd2, exp_rd:32'hF};
      tbl[6] = '{src:4'b0000, ack:1'b0, addr:2'd2, we:1'b0, wdata:32'h0, exp_int:1'b1, exp_id:3'd1, exp_rd:32'h101};
      tbl[7] = '{src:4'b0000, ack:1'b1, addr:2'd0, we:1'b0, wdata:32'h0, exp_int:1'b0, exp_id:3'd1, exp_rd:32'h0};
      tbl[8] = '{src:4'b0000, ack:1'b0, addr:2'd2, we:1'b0, wdata:32'h0, exp_int:1'b0, exp_id:3'd1, exp_rd:32'h1};

      reset = 1'b0; irq_src = 4'd0; INT_ACK = 1'b0;
      bus_addr = 2'd0; bus_we = 1'b0; bus_wdata = 32'd0;
      model_reset();
      idle(3);
      check("reset_int", 32'(INT), 32'd0);
      check("reset_int_id", 32'(int_id), 32'd0);
      read_chk("reset_mask", 2'd1, 32'hF);
      read_chk("reset_pending", 2'd0, 32'h0);
      reset = 1'b1;

      // 1: single source, latency, ack and holdoff
      first = 0;
      irq_src = 4'b0100;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 3) irq_src = 4'd0;
         if (INT === 1'b1 && first == 0) first = i;
      end
      check("t1_latency", 32'(first), 32'(SYNC_STAGES + 2));
      check("t1_int_id", 32'(int_id), 32'd2);
      ack_pulse();
      check("t1_int_after_ack", 32'(INT), 32'd0);
      read_chk("t1_pending", 2'd0, 32'h0);
      step();
      check("t1_hold1", 32'(INT), 32'd0);
      step();
      check("t1_hold2", 32'(INT), 32'd0);
      idle(4);

      // 4: capture while masked, request on unmask
      for (int k = 0; k < 9; k++) begin
         irq_src = tbl[k].src; INT_ACK = tbl[k].ack; bus_addr = tbl[k].addr;
         bus_we = tbl[k].we; bus_wdata = tbl[k].wdata;
         step();
         check($sformatf("tbl%0d_int", k), 32'(INT), 32'(tbl[k].exp_int));
         check($sformatf("tbl%0d_id", k), 32'(int_id), 32'(tbl[k].exp_id));
         check($sformatf("tbl%0d_rdata", k), bus_rdata, tbl[k].exp_rd);
      end
      irq_src = 4'd0; INT_ACK = 1'b0; bus_we = 1'b0;
      idle(4);

      // 2: simultaneous rises served in priority order, holdoff between them
      pulse_src(4'b1010);
      wait_int(20, n);
      check("t2_first_id", 32'(int_id), 32'd1);
      ack_pulse();
      wait_int(20, n);
      check("t2_holdoff_gap", 32'(n), 32'(HOLDOFF + 1));
      check("t2_second_id", 32'(int_id), 32'd3);
      ack_pulse();
      read_chk("t2_pending", 2'd0, 32'h0);
      idle(4);

      // 3: no pre-emption by a higher-priority source
      pulse_src(4'b1000);
      wait_int(20, n);
      check("t3_id3", 32'(int_id), 32'd3);
      pulse_src(4'b0001);
      idle(3);
      check("t3_still_id3", 32'(int_id), 32'd3);
      check("t3_still_int", 32'(INT), 32'd1);
      ack_pulse();
      wait_int(20, n);
      check("t3_id0", 32'(int_id), 32'd0);
      ack_pulse();
      idle(4);

      // 5: withdraw by W1C, then a stray ack is ignored
      pulse_src(4'b0100);
      wait_int(20, n);
      bus_write(2'd0, 32'h4);
      check("t5_withdraw_int", 32'(INT), 32'd0);
      read_chk("t5_active", 2'd2, 32'h2);
      ack_pulse();
      check("t5_stray_int", 32'(INT), 32'd0);
      read_chk("t5_pending", 2'd0, 32'h0);
      idle(4);

      // 6: new edge coincident with ack, then reset during a request
      pulse_src(4'b0100);
      wait_int(20, n);
      irq_src = 4'b0100;
      idle(2);
      INT_ACK = 1'b1;
      step();
      INT_ACK = 1'b0;
      irq_src = 4'd0;
      check("t6_int_after_ack", 32'(INT), 32'd0);
      read_chk("t6_pending_kept", 2'd0, 32'h4);
      wait_int(20, n);
      check("t6_rereq_id", 32'(int_id), 32'd2);
      reset = 1'b0;
      model_reset();
      #1;
      check("t6_async_int", 32'(INT), 32'd0);
      read_chk("t6_reset_mask", 2'd1, 32'hF);
      idle(2);
      reset = 1'b1;
      idle(2);

      // randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) irq_src = 4'($urandom);
         INT_ACK   = ($urandom_range(0, 3) == 0);
         bus_we    = ($urandom_range(0, 9) == 0);
         bus_addr  = 2'($urandom);
         bus_wdata = $urandom;
         step();
      end
      INT_ACK = 1'b0; bus_we = 1'b0; irq_src = 4'd0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
